// File: rtl/intf_stim_gen_pkg.sv
// Shared state encoding and default parameter values for the intf_stim_gen stimulus generator.
package intf_stim_gen_pkg;

  localparam int A_DEFAULT = 100;
  localparam int D_DEFAULT = 1;
  localparam int W_DEFAULT = 8;

  // Gap timer width: holds the largest legal idle gap (255).
  localparam int GAP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/intf_stim_gen_gap_ctr.sv
// Idle-gap timer: loads D on a transfer, counts down while the FSM sits in GAP,
// and flags the final idle cycle so the FSM can return to SEND.
module intf_stim_gen_gap_ctr
  import intf_stim_gen_pkg::*;
#(
  parameter int D = D_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = GAP_W'(D);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The first GAP cycle sees cnt_q == D, so expiring at 1 yields exactly D idle cycles.
  assign expired = en && (cnt_q == GAP_W'(1));

endmodule

// File: rtl/intf_stim_gen.sv
// Valid/ready stimulus generator: emits A beats of incrementing data with D idle cycles
// between beats. Define INTF_STIM_GEN_CHECKSUM_EN to add a running checksum output.
module intf_stim_gen
  import intf_stim_gen_pkg::*;
#(
  parameter int A = A_DEFAULT,
  parameter int D = D_DEFAULT,
  parameter int W = W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     ready,
  output logic                     valid,
  output logic [W-1:0]             data,
  output logic                     last,
  output logic                     done,
  output logic [$clog2(A+1)-1:0]   count
`ifdef INTF_STIM_GEN_CHECKSUM_EN
  ,
  output logic [W-1:0]             checksum
`endif
);

  localparam int CW = $clog2(A + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(A - 1);

  state_e        state_q;
  state_e        state_d;
  logic [W-1:0]  data_q;
  logic [W-1:0]  data_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic xfer;
  logic is_last;
  logic run_start;
  logic gap_expired;

  assign valid     = (state_q == SEND);
  assign xfer      = valid && ready;
  assign is_last   = (count_q == LAST_IDX);
  assign last      = valid && is_last;
  assign done      = (state_q == DONE);
  assign data      = data_q;
  assign count     = count_q;
  // start is only honoured when no run is in flight.
  assign run_start = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (run_start) begin
          state_d = SEND;
          data_d  = '0;
          count_d = '0;
        end
      end
      SEND: begin
        if (xfer) begin
          data_d  = data_q + W'(1);
          count_d = count_q + CW'(1);
          if (is_last) begin
            state_d = DONE;
          end else if (D > 0) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_expired) begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  generate
    if (D > 0) begin : g_gap
      logic gap_load;
      assign gap_load = xfer && !is_last;

      intf_stim_gen_gap_ctr #(
        .D(D)
      ) u_gap_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (gap_load),
        .en     (state_q == GAP),
        .expired(gap_expired)
      );
    end else begin : g_no_gap
      assign gap_expired = 1'b0;
    end
  endgenerate

`ifdef INTF_STIM_GEN_CHECKSUM_EN
  logic [W-1:0] checksum_q;
  logic [W-1:0] checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (run_start) begin
      checksum_d = '0;
    end else if (xfer) begin
      checksum_d = checksum_q + data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_intf_stim_gen.sv
// Directed self-checking bench for intf_stim_gen: five instances cover back-to-back,
// gapped, stalled, wrapping and mid-run-reset runs (plus checksum when enabled).
`timescale 1ns/1ps
module tb_intf_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // u0: A=4 D=0 W=8
  logic rst0_n, start0, ready0, valid0, last0, done0;
  logic [7:0] data0;
  logic [2:0] count0;
  // u1: A=3 D=2 W=8
  logic rst1_n, start1, ready1, valid1, last1, done1;
  logic [7:0] data1;
  logic [1:0] count1;
  // u2: A=2 D=1 W=8
  logic rst2_n, start2, ready2, valid2, last2, done2;
  logic [7:0] data2;
  logic [1:0] count2;
  // u3: A=6 D=0 W=2
  logic rst3_n, start3, ready3, valid3, last3, done3;
  logic [1:0] data3;
  logic [2:0] count3;
  // u4: defaults A=100 D=1 W=8
  logic rst4_n, start4, ready4, valid4, last4, done4;
  logic [7:0] data4;
  logic [6:0] count4;
`ifdef INTF_STIM_GEN_CHECKSUM_EN
  logic [7:0] csum0, csum1, csum2, csum4;
  logic [1:0] csum3;
`endif

  intf_stim_gen #(.A(4), .D(0), .W(8)) u0 (
    .clk(clk), .rst_n(rst0_n), .start(start0), .ready(ready0), .valid(valid0),
    .data(data0), .last(last0), .done(done0), .count(count0)
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    , .checksum(csum0)
`endif
  );

  intf_stim_gen #(.A(3), .D(2), .W(8)) u1 (
    .clk(clk), .rst_n(rst1_n), .start(start1), .ready(ready1), .valid(valid1),
    .data(data1), .last(last1), .done(done1), .count(count1)
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    , .checksum(csum1)
`endif
  );

  intf_stim_gen #(.A(2), .D(1), .W(8)) u2 (
    .clk(clk), .rst_n(rst2_n), .start(start2), .ready(ready2), .valid(valid2),
    .data(data2), .last(last2), .done(done2), .count(count2)
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    , .checksum(csum2)
`endif
  );

  intf_stim_gen #(.A(6), .D(0), .W(2)) u3 (
    .clk(clk), .rst_n(rst3_n), .start(start3), .ready(ready3), .valid(valid3),
    .data(data3), .last(last3), .done(done3), .count(count3)
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    , .checksum(csum3)
`endif
  );

  intf_stim_gen u4 (
    .clk(clk), .rst_n(rst4_n), .start(start4), .ready(ready4), .valid(valid4),
    .data(data4), .last(last4), .done(done4), .count(count4)
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    , .checksum(csum4)
`endif
  );

  // Outputs are sampled 1 ns after the rising edge; inputs set here apply at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    {rst0_n, rst1_n, rst2_n, rst3_n, rst4_n} = '0;
    {start0, start1, start2, start3, start4} = '0;
    {ready0, ready1, ready2, ready3, ready4} = '0;
    tick();
    tick();
    checks++;
    if ({valid0, last0, done0, data0, count0} !== 14'd0) begin
      errors++; $display("FAIL reset_u0: got %h want 0", {valid0, last0, done0, data0, count0});
    end
    checks++;
    if ({valid1, last1, done1, data1, count1} !== 13'd0) begin
      errors++; $display("FAIL reset_u1: got %h want 0", {valid1, last1, done1, data1, count1});
    end
    checks++;
    if ({valid2, last2, done2, data2, count2} !== 13'd0) begin
      errors++; $display("FAIL reset_u2: got %h want 0", {valid2, last2, done2, data2, count2});
    end
    checks++;
    if ({valid3, last3, done3, data3, count3} !== 8'd0) begin
      errors++; $display("FAIL reset_u3: got %h want 0", {valid3, last3, done3, data3, count3});
    end
    checks++;
    if ({valid4, last4, done4, data4, count4} !== 18'd0) begin
      errors++; $display("FAIL reset_u4: got %h want 0", {valid4, last4, done4, data4, count4});
    end
    {rst0_n, rst1_n, rst2_n, rst3_n, rst4_n} = '1;
    ready0 = 1'b1;
    tick();
    // Released but not started: stays idle even with ready high.
    checks++;
    if ({valid0, done0} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got %b want 00", {valid0, done0});
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] got, exp;
    ready0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = {valid0, last0, done0, data0, count0};
      exp = {1'b1, (i == 3), 1'b0, 8'(i), 3'(i)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, got, exp);
      end
      $display("b2b beat %0d data=%0d last=%b", i, data0, last0);
      start0 = (i == 1);
      tick();
      start0 = 1'b0;
    end
    checks++;
    if ({valid0, done0, count0} !== {1'b0, 1'b1, 3'd4}) begin
      errors++; $display("FAIL b2b_done: got %h want %h", {valid0, done0, count0}, {1'b0, 1'b1, 3'd4});
    end
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    checks++;
    if (csum0 !== 8'd6) begin
      errors++; $display("FAIL checksum_run: got %0d want 6", csum0);
    end
`endif
    tick();
    tick();
    checks++;
    if ({valid0, done0, count0} !== {1'b0, 1'b1, 3'd4}) begin
      errors++; $display("FAIL done_hold: got %h want %h", {valid0, done0, count0}, {1'b0, 1'b1, 3'd4});
    end
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checks++;
    if ({valid0, done0, data0, count0} !== {1'b1, 1'b0, 8'd0, 3'd0}) begin
      errors++; $display("FAIL restart: got %h want %h", {valid0, done0, data0, count0}, {1'b1, 1'b0, 8'd0, 3'd0});
    end
`ifdef INTF_STIM_GEN_CHECKSUM_EN
    checks++;
    if (csum0 !== 8'd0) begin
      errors++; $display("FAIL checksum_restart: got %0d want 0", csum0);
    end
`endif
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({done0, count0} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL restart_done: got %h want %h", {done0, count0}, {1'b1, 3'd4});
    end
  endtask

  task automatic test_gap();
    logic       exp_v;
    logic [1:0] exp_cnt;
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_v   = (k == 0) || (k == 3) || (k == 6);
      exp_cnt = 2'((k + 2) / 3);
      checks++;
      if ({valid1, last1, done1, count1} !== {exp_v, (k == 6), (k >= 7), exp_cnt}) begin
        errors++;
        $display("FAIL gap_cycle%0d: got %b want %b", k, {valid1, last1, done1, count1},
                 {exp_v, (k == 6), (k >= 7), exp_cnt});
      end
      if (exp_v) begin
        checks++;
        if (data1 !== 8'(k / 3)) begin
          errors++; $display("FAIL gap_data%0d: got %0d want %0d", k, data1, k / 3);
        end
        $display("gap beat %0d data=%0d cycle=%0d", k / 3, data1, k);
      end
      start1 = (k == 1);
      tick();
      start1 = 1'b0;
    end
  endtask

  task automatic test_stall();
    ready2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) ready2 = 1'b1;
      checks++;
      if ({valid2, last2, data2, count2} !== {1'b1, 1'b0, 8'd0, 2'd0}) begin
        errors++; $display("FAIL stall_hold%0d: got %h want %h", k, {valid2, last2, data2, count2}, {1'b1, 1'b0, 8'd0, 2'd0});
      end
      tick();
    end
    $display("stall beat 0 accepted after 5 wait cycles");
    checks++;
    if ({valid2, count2} !== {1'b0, 2'd1}) begin
      errors++; $display("FAIL stall_gap: got %b want %b", {valid2, count2}, {1'b0, 2'd1});
    end
    tick();
    checks++;
    if ({valid2, last2, data2, count2} !== {1'b1, 1'b1, 8'd1, 2'd1}) begin
      errors++; $display("FAIL stall_beat1: got %h want %h", {valid2, last2, data2, count2}, {1'b1, 1'b1, 8'd1, 2'd1});
    end
    tick();
    $display("stall beat 1 accepted");
    checks++;
    if ({valid2, done2, count2} !== {1'b0, 1'b1, 2'd2}) begin
      errors++; $display("FAIL stall_done: got %b want %b", {valid2, done2, count2}, {1'b0, 1'b1, 2'd2});
    end
  endtask

  task automatic test_wrap();
    logic [6:0] got, exp;
    ready3 = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      got = {valid3, last3, data3, count3};
      exp = {1'b1, (i == 5), 2'(i % 4), 3'(i)};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wrap_beat%0d: got %b want %b", i, got, exp);
      end
      $display("wrap beat %0d data=%0d last=%b", i, data3, last3);
      tick();
    end
    checks++;
    if ({valid3, done3, count3} !== {1'b0, 1'b1, 3'd6}) begin
      errors++; $display("FAIL wrap_done: got %b want %b", {valid3, done3, count3}, {1'b0, 1'b1, 3'd6});
    end
  endtask

  task automatic test_reset_mid_run();
    ready4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if ({valid4, count4} !== {1'b0, 7'd2}) begin
      errors++; $display("FAIL midrun_before: got %h want %h", {valid4, count4}, {1'b0, 7'd2});
    end
    $display("midrun 2 beats accepted, asserting reset");
    rst4_n = 1'b0;
    start4 = 1'b1;
    tick();
    checks++;
    if ({valid4, last4, done4, data4, count4} !== 18'd0) begin
      errors++; $display("FAIL midrun_reset: got %h want 0", {valid4, last4, done4, data4, count4});
    end
    tick();
    rst4_n = 1'b1;
    start4 = 1'b0;
    tick();
    checks++;
    if ({valid4, done4, count4} !== 9'd0) begin
      errors++; $display("FAIL start_in_reset: got %h want 0", {valid4, done4, count4});
    end
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checks++;
    if ({valid4, last4, data4, count4} !== {1'b1, 1'b0, 8'd0, 7'd0}) begin
      errors++; $display("FAIL midrun_restart: got %h want %h", {valid4, last4, data4, count4}, {1'b1, 1'b0, 8'd0, 7'd0});
    end
    tick();
    tick();
    checks++;
    if ({valid4, data4, count4} !== {1'b1, 8'd1, 7'd1}) begin
      errors++; $display("FAIL midrun_second: got %h want %h", {valid4, data4, count4}, {1'b1, 8'd1, 7'd1});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_stall();
    test_wrap();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/intf_stim_gen.md
INTF_STIM_GEN -- requirements
Module: intf_stim_gen

Interface
REQ-001 The block SHALL have parameter A, default 100: number of transactions per run; legal range is 1 to 65535.
REQ-002 The block SHALL have parameter D, default 1: idle gap in cycles after each accepted transaction; legal range is 0 to 255.
REQ-003 The block SHALL have parameter W, default 8: data width; legal range is 1 to 32.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port start, input, 1 bit: one-cycle pulse that begins a run.
REQ-007 Port ready, input, 1 bit: the downstream interface accepts the data.
REQ-008 Port valid, output, 1 bit: data is being offered.
REQ-009 Port data, output, W bits: transaction payload.
REQ-010 Port last, output, 1 bit: the current beat is transaction A of the run.
REQ-011 Port done, output, 1 bit: the run is complete; it stays high until the next start.
REQ-012 Port count, output, $clog2(A+1) bits: number of transactions accepted in the current run.

Function
REQ-013 The state machine SHALL have the states IDLE, SEND, GAP and DONE.
REQ-014 IDLE->SEND on start; valid SHALL assert in the cycle after start (latency 1).
REQ-015 A transfer SHALL occur on a cycle with valid&&ready; it SHALL increment count by 1.
REQ-016 While valid=1 and ready=0, data and last SHALL hold stable and valid SHALL stay high; no retraction.
REQ-017 data SHALL equal the transaction index mod 2^W, starting at 0 and wrapping silently at 2^W.
REQ-018 last SHALL be high only when valid=1 and count==A-1.
REQ-019 After a non-last transfer with D>0: SEND->GAP; valid SHALL stay low for exactly D cycles, then return to SEND.
REQ-020 After a non-last transfer with D=0: the FSM SHALL stay in SEND and offer the next beat in the next cycle (back-to-back).
REQ-021 After the last transfer, the FSM SHALL go to DONE and done SHALL be 1 in the next cycle; valid SHALL be 0.
REQ-022 DONE->SEND on start: count SHALL clear, data index SHALL restart at 0, and done SHALL drop in the same cycle that valid rises.
REQ-023 start in SEND or GAP SHALL be ignored.
REQ-024 ready while valid=0 SHALL have no effect.

Reset
REQ-025 When rst_n=0 at a clock edge: state=IDLE, valid=0, data=0, last=0, done=0, count=0.
REQ-026 Reset asserted mid-run SHALL abort the run with no further transfers; the next run SHALL restart at index 0.
REQ-027 start sampled while rst_n=0 SHALL be ignored.

Configuration
REQ-028 With macro INTF_STIM_GEN_CHECKSUM_EN defined, the block SHALL have an extra output checksum, W bits: the mod-2^W sum of all transferred data in the run. It SHALL clear on reset and on start, and update on each transfer.
REQ-029 Without INTF_STIM_GEN_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package intf_stim_gen_pkg SHALL hold the state enum typedef and the default constants for A, D and W.
REQ-031 The gap timer SHALL be the sub-module intf_stim_gen_gap_ctr (load D, count down, assert expired); it SHALL be omitted when D=0.

Verification
REQ-032 Scenario: A=4, D=0, ready tied to 1, start pulse -> data 0,1,2,3 on consecutive cycles, last on data 3, done=1 one cycle later, count=4.
REQ-033 Scenario: A=3, D=2, ready=1 -> exactly 2 idle cycles between beats, 7 cycles from the first valid to the last transfer.
REQ-034 Scenario: A=2, ready low for 5 cycles on the first beat -> valid and data=0 held for 5 cycles, then transfer; total of 2 transfers.
REQ-035 Scenario: W=2, A=6, D=0 -> data 0,1,2,3,0,1; last on the second 1.
REQ-036 Scenario: rst_n low after 2 of 100 transfers -> all outputs 0 next cycle; a new start yields data starting at 0.
REQ-037 Scenario: INTF_STIM_GEN_CHECKSUM_EN defined, A=4, W=8 -> checksum=6; start during SEND is ignored; start in DONE restarts with checksum=0.
